mac_tx_frame_gen: RTL and testbench

MAC_TX_FRAME_GEN -- requirements
Module: mac_tx_frame_gen

---
 rtl/mac_pkg.sv | 29 ++
 rtl/mac_lfsr.sv | 56 +++++
 rtl/mac_tx_frame_gen.sv | 184 ++++++++++++++++++
 tb/tb_mac_tx_frame_gen.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared types and constants for the MAC transmit frame generator.
// MAC_TX_PAD_EN adds the PAD state used for minimum-length padding.
package mac_pkg;

    // state | meaning
    // IDLE  | waiting for first byte of a frame (not consumed)
    // PRE   | preamble bytes and SFD
    // DATA  | forwarding payload bytes, CRC accumulating
    // PAD   | zero padding up to the minimum payload length
    // FCS   | four CRC bytes, least significant first
    // DRAIN | underrun recovery, discarding input up to tlast
    // IFG   | inter-frame gap
`ifdef MAC_TX_PAD_EN
    typedef enum logic [2:0] {
        IDLE, PRE, DATA, PAD, FCS, DRAIN, IFG
    } tx_state_e;
`else
    typedef enum logic [2:0] {
        IDLE, PRE, DATA, FCS, DRAIN, IFG
    } tx_state_e;
`endif

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_XOR       = 32'hFFFFFFFF;

endpackage

// File: rtl/mac_lfsr.sv
// Galois-form LFSR advanced DATA_WIDTH bits per enabled cycle; used as the FCS CRC.
// REVERSE=1 shifts LSB-first with the reflected polynomial.
module mac_lfsr #(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] POLY       = 32'h04C11DB7,
    parameter logic [WIDTH-1:0] INIT       = '1,
    parameter bit               REVERSE    = 1'b1,
    parameter int               DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  init_i,
    input  logic                  en_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [WIDTH-1:0]      state_o
);

    function automatic logic [WIDTH-1:0] reflect(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        for (int b = 0; b < WIDTH; b++) r[b] = v[WIDTH-1-b];
        return r;
    endfunction

    localparam logic [WIDTH-1:0] POLY_REV = reflect(POLY);

    logic [WIDTH-1:0] state_q, state_d;
    logic             fb;

    always_comb begin
        state_d = state_q;
        fb      = 1'b0;
        if (init_i) begin
            state_d = INIT;
        end else if (en_i) begin
            for (int i = 0; i < DATA_WIDTH; i++) begin
                if (REVERSE) begin
                    fb      = state_d[0] ^ data_i[i];
                    state_d = state_d >> 1;
                    if (fb) state_d = state_d ^ POLY_REV;
                end else begin
                    fb      = state_d[WIDTH-1] ^ data_i[DATA_WIDTH-1-i];
                    state_d = state_d << 1;
                    if (fb) state_d = state_d ^ POLY;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= INIT;
        else         state_q <= state_d;
    end

    assign state_o = state_q;

endmodule

// File: rtl/mac_tx_frame_gen.sv
// GMII transmit framer: preamble/SFD, payload, optional padding, CRC-32 FCS, IFG.
// Build macro MAC_TX_PAD_EN enables padding of short frames to MIN_PAYLOAD.
module mac_tx_frame_gen
    import mac_pkg::*;
#(
    parameter int IFG_BYTES   = 12,
    parameter int MIN_PAYLOAD = 60
) (
    input  logic       phy_tx_clk,
    input  logic       phy_tx_rst_n,
    input  logic [7:0] mac_tdata_in,
    input  logic       mac_tvalid_in,
    output logic       mac_tready_out,
    input  logic       mac_tlast_in,
    output logic [7:0] phy_txd_out,
    output logic       phy_tvalid_out,
    output logic       phy_terr_out,
    output logic       tx_busy_out
);

    localparam logic [7:0] IFG_LOAD = 8'(IFG_BYTES - 1);

    tx_state_e   state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  ifg_q, ifg_d;
    logic [7:0]  txd_q, txd_d;
    logic        tvalid_q, tvalid_d;
    logic        terr_q, terr_d;
    logic        crc_init, crc_en;
    logic [7:0]  crc_data;
    logic [31:0] crc_state, fcs_word;

`ifdef MAC_TX_PAD_EN
    localparam logic [10:0] MIN_CNT = 11'(MIN_PAYLOAD);
    logic [10:0] cnt_q, cnt_d, cnt_inc;
    assign cnt_inc = (cnt_q == 11'h7FF) ? cnt_q : cnt_q + 11'd1;
`else
    logic [10:0] unused_min_payload;
    assign unused_min_payload = 11'(MIN_PAYLOAD);
`endif

    assign mac_tready_out = (state_q == DATA) || (state_q == DRAIN);
    assign tx_busy_out    = (state_q != IDLE);
    assign fcs_word       = crc_state ^ CRC_XOR;

    // Output bytes are registered, so the first preamble byte is launched from IDLE;
    // this keeps the wire gap between frames at exactly IFG_BYTES.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        ifg_d    = ifg_q;
        txd_d    = 8'h00;
        tvalid_d = 1'b0;
        terr_d   = 1'b0;
        crc_init = 1'b0;
        crc_en   = 1'b0;
        crc_data = mac_tdata_in;
`ifdef MAC_TX_PAD_EN
        cnt_d    = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (mac_tvalid_in) begin
                    state_d  = PRE;
                    idx_d    = 3'd1;
                    txd_d    = PREAMBLE_BYTE;
                    tvalid_d = 1'b1;
                    crc_init = 1'b1;
`ifdef MAC_TX_PAD_EN
                    cnt_d    = '0;
`endif
                end
            end
            PRE: begin
                tvalid_d = 1'b1;
                if (idx_q == 3'd7) begin
                    txd_d   = SFD_BYTE;
                    state_d = DATA;
                end else begin
                    txd_d = PREAMBLE_BYTE;
                    idx_d = idx_q + 3'd1;
                end
            end
            DATA: begin
                tvalid_d = 1'b1;
                if (mac_tvalid_in) begin
                    txd_d  = mac_tdata_in;
                    crc_en = 1'b1;
`ifdef MAC_TX_PAD_EN
                    cnt_d  = cnt_inc;
`endif
                    if (mac_tlast_in) begin
                        idx_d = 3'd0;
`ifdef MAC_TX_PAD_EN
                        state_d = (cnt_inc < MIN_CNT) ? PAD : FCS;
`else
                        state_d = FCS;
`endif
                    end
                end else begin
                    terr_d  = 1'b1;
                    state_d = DRAIN;
                end
            end
`ifdef MAC_TX_PAD_EN
            PAD: begin
                tvalid_d = 1'b1;
                crc_en   = 1'b1;
                crc_data = 8'h00;
                cnt_d    = cnt_inc;
                if (cnt_inc >= MIN_CNT) begin
                    idx_d   = 3'd0;
                    state_d = FCS;
                end
            end
`endif
            FCS: begin
                tvalid_d = 1'b1;
                txd_d    = fcs_word[{idx_q[1:0], 3'b000} +: 8];
                if (idx_q == 3'd3) begin
                    ifg_d   = IFG_LOAD;
                    state_d = IFG;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            DRAIN: begin
                if (mac_tvalid_in && mac_tlast_in) begin
                    ifg_d   = IFG_LOAD;
                    state_d = IFG;
                end
            end
            IFG: begin
                if (ifg_q == 8'd0) state_d = IDLE;
                else               ifg_d   = ifg_q - 8'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge phy_tx_clk or negedge phy_tx_rst_n) begin
        if (!phy_tx_rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            ifg_q    <= '0;
            txd_q    <= '0;
            tvalid_q <= 1'b0;
            terr_q   <= 1'b0;
`ifdef MAC_TX_PAD_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            ifg_q    <= ifg_d;
            txd_q    <= txd_d;
            tvalid_q <= tvalid_d;
            terr_q   <= terr_d;
`ifdef MAC_TX_PAD_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    mac_lfsr #(
        .WIDTH      (32),
        .POLY       (CRC_POLY),
        .INIT       (CRC_INIT),
        .REVERSE    (1'b1),
        .DATA_WIDTH (8)
    ) u_crc (
        .clk_i   (phy_tx_clk),
        .rst_ni  (phy_tx_rst_n),
        .init_i  (crc_init),
        .en_i    (crc_en),
        .data_i  (crc_data),
        .state_o (crc_state)
    );

    assign phy_txd_out    = txd_q;
    assign phy_tvalid_out = tvalid_q;
    assign phy_terr_out   = terr_q;

endmodule

// File: tb/tb_mac_tx_frame_gen.sv
// Scoreboard bench for mac_tx_frame_gen: frame table plus back-to-back and mid-frame reset sequences.
module tb_mac_tx_frame_gen;

    localparam int IFG  = 12;
    localparam int MINP = 60;
`ifdef MAC_TX_PAD_EN
    localparam bit PAD_ON = 1'b1;
`else
    localparam bit PAD_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] mac_tdata_in = 8'h00;
    logic       mac_tvalid_in = 1'b0;
    logic       mac_tlast_in = 1'b0;
    logic       mac_tready_out;
    logic [7:0] phy_txd_out;
    logic       phy_tvalid_out;
    logic       phy_terr_out;
    logic       tx_busy_out;

    always #5 clk = ~clk;

    mac_tx_frame_gen #(.IFG_BYTES(IFG), .MIN_PAYLOAD(MINP)) dut (
        .phy_tx_clk     (clk),
        .phy_tx_rst_n   (rst_n),
        .mac_tdata_in   (mac_tdata_in),
        .mac_tvalid_in  (mac_tvalid_in),
        .mac_tready_out (mac_tready_out),
        .mac_tlast_in   (mac_tlast_in),
        .phy_txd_out    (phy_txd_out),
        .phy_tvalid_out (phy_tvalid_out),
        .phy_terr_out   (phy_terr_out),
        .tx_busy_out    (tx_busy_out)
    );

    typedef struct {
        int          len;
        int          drop_after;
        bit          ascii;
        int          seed;
        int          exp_txen;
        int          exp_terr;
        bit          chk_fcs;
        logic [31:0] exp_fcs;
    } vec_t;

    vec_t       vecs[4];
    logic [8:0] exp_q[$];
    int         n_cmp = 0, n_bad = 0;
    int         txen_cnt = 0, terr_cnt = 0, idle_run = 0, last_gap = 0;
    logic [31:0] last4 = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pay_byte(input vec_t v, input int i);
        if (v.ascii) return 8'(8'h31 + i);
        return 8'(v.seed + i * 13);
    endfunction

    function automatic logic [31:0] crc_upd(input logic [31:0] c_in, input logic [7:0] b);
        logic [31:0] c;
        c = c_in;
        for (int k = 0; k < 8; k++) begin
            if (c[0] ^ b[k]) c = (c >> 1) ^ 32'hEDB88320;
            else             c = c >> 1;
        end
        return c;
    endfunction

    function automatic logic [31:0] frame_fcs(input vec_t v);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < v.len; i++) c = crc_upd(c, pay_byte(v, i));
        if (PAD_ON) for (int i = v.len; i < MINP; i++) c = crc_upd(c, 8'h00);
        return ~c;
    endfunction

    task automatic push_expected(input vec_t v);
        logic [31:0] fcs;
        int nd;
        for (int i = 0; i < 7; i++) exp_q.push_back({1'b0, 8'h55});
        exp_q.push_back({1'b0, 8'hD5});
        nd = (v.drop_after > 0) ? v.drop_after : v.len;
        for (int i = 0; i < nd; i++) exp_q.push_back({1'b0, pay_byte(v, i)});
        if (v.drop_after > 0) begin
            exp_q.push_back(9'h100);
        end else begin
            if (PAD_ON) for (int i = v.len; i < MINP; i++) exp_q.push_back(9'h000);
            fcs = frame_fcs(v);
            for (int k = 0; k < 4; k++) exp_q.push_back({1'b0, fcs[8*k +: 8]});
        end
    endtask

    // Drives one frame; reset_at > 0 pulses reset right after that many bytes are accepted.
    task automatic send(input vec_t v, input int reset_at);
        int acc = 0, waits = 0;
        bit hs, dropped = 0;
        mac_tdata_in  = pay_byte(v, 0);
        mac_tlast_in  = (v.len == 1);
        mac_tvalid_in = 1'b1;
        while (acc < v.len && waits < 5000) begin
            @(negedge clk);
            hs = mac_tready_out && mac_tvalid_in;
            @(posedge clk);
            #1;
            waits++;
            if (hs) begin
                acc++;
                if (reset_at > 0 && acc == reset_at) begin
                    rst_n = 1'b0;
                    #1;
                    chk("rst_txd", 32'(phy_txd_out), 32'h00);
                    chk("rst_tvalid", 32'(phy_tvalid_out), 32'h0);
                    chk("rst_terr", 32'(phy_terr_out), 32'h0);
                    chk("rst_tready", 32'(mac_tready_out), 32'h0);
                    chk("rst_busy", 32'(tx_busy_out), 32'h0);
                    exp_q.delete();
                    mac_tvalid_in = 1'b0;
                    mac_tlast_in  = 1'b0;
                    @(negedge clk);
                    rst_n = 1'b1;
                    return;
                end
                if (acc < v.len) begin
                    mac_tdata_in = pay_byte(v, acc);
                    mac_tlast_in = (acc == v.len - 1);
                    if (v.drop_after > 0 && acc == v.drop_after && !dropped) begin
                        mac_tvalid_in = 1'b0;
                        dropped = 1;
                    end
                end else begin
                    mac_tvalid_in = 1'b0;
                    mac_tlast_in  = 1'b0;
                end
            end else if (!mac_tvalid_in) begin
                mac_tvalid_in = 1'b1;
            end
        end
        chk("bytes_accepted", 32'(acc), 32'(v.len));
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tx_busy_out && n < 3000);
        chk("idle_timeout", 32'(tx_busy_out), 32'h0);
    endtask

    always @(negedge clk) begin
        if (phy_tvalid_out) begin
            txen_cnt++;
            if (phy_terr_out) terr_cnt++;
            if (idle_run > 0) last_gap = idle_run;
            idle_run = 0;
            last4 = {phy_txd_out, last4[31:8]};
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL wire_unexpected: got %0h expected no byte", {phy_terr_out, phy_txd_out});
            end else begin
                chk("wire_byte", 32'({phy_terr_out, phy_txd_out}), 32'(exp_q.pop_front()));
            end
        end else begin
            idle_run++;
            if (phy_terr_out) begin
                n_cmp++;
                n_bad++;
                $display("FAIL terr_without_txen: got 1 expected 0");
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t rv;
        #1 rst_n = 1'b0;
        #2;
        chk("reset_txd", 32'(phy_txd_out), 32'h00);
        chk("reset_tvalid", 32'(phy_tvalid_out), 32'h0);
        chk("reset_terr", 32'(phy_terr_out), 32'h0);
        chk("reset_tready", 32'(mac_tready_out), 32'h0);
        chk("reset_busy", 32'(tx_busy_out), 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        vecs[0] = '{9,   0,  1'b1, 0,     PAD_ON ? 72 : 21, 0, 1'b1, 32'h0};
        vecs[1] = '{64,  0,  1'b0, 16,    76,               0, 1'b1, 32'h0};
        vecs[2] = '{100, 20, 1'b0, 3,     29,               1, 1'b0, 32'h0};
        vecs[3] = '{1,   0,  1'b0, 165,   PAD_ON ? 72 : 13, 0, 1'b1, 32'h0};
        vecs[0].exp_fcs = PAD_ON ? frame_fcs(vecs[0]) : 32'hCBF43926;
        vecs[1].exp_fcs = frame_fcs(vecs[1]);
        vecs[3].exp_fcs = frame_fcs(vecs[3]);

        for (int k = 0; k < 4; k++) begin
            txen_cnt = 0;
            terr_cnt = 0;
            push_expected(vecs[k]);
            send(vecs[k], 0);
            wait_idle();
            chk($sformatf("txen_cycles_v%0d", k), 32'(txen_cnt), 32'(vecs[k].exp_txen));
            chk($sformatf("terr_cycles_v%0d", k), 32'(terr_cnt), 32'(vecs[k].exp_terr));
            chk($sformatf("queue_left_v%0d", k), 32'(exp_q.size()), 32'h0);
            if (vecs[k].chk_fcs) chk($sformatf("fcs_v%0d", k), last4, vecs[k].exp_fcs);
        end

        // back-to-back: second frame queued while the first is still in FCS
        push_expected(vecs[0]);
        send(vecs[0], 0);
        push_expected(vecs[1]);
        send(vecs[1], 0);
        wait_idle();
        chk("b2b_gap", 32'(last_gap), 32'(IFG));
        chk("b2b_queue_left", 32'(exp_q.size()), 32'h0);

        // reset in the middle of a frame, then a clean frame
        rv = '{50, 0, 1'b0, 77, 0, 0, 1'b0, 32'h0};
        push_expected(rv);
        send(rv, 30);
        repeat (2) @(negedge clk);
        chk("post_reset_busy", 32'(tx_busy_out), 32'h0);
        txen_cnt = 0;
        push_expected(vecs[0]);
        send(vecs[0], 0);
        wait_idle();
        chk("post_reset_txen", 32'(txen_cnt), 32'(vecs[0].exp_txen));
        chk("post_reset_queue_left", 32'(exp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
